// File: rtl/dat_mem_arb.sv
// Two-port arbiter for the single-port 256x8 data memory: round-robin on conflict,
// optional lock for bursts of at most MAX_LOCK grants, registered per-port read return.
module dat_mem_arb #(
  parameter int MAX_LOCK = 16,
  parameter int AW       = 8,
  parameter int DW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_dat_out
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

  owner_t        owner_q, owner_d;
  logic          last_b_q, last_b_d;   // 1: B was granted most recently
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, b_rdata_q;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      unique case (owner_q)
        OWN_A:   a_gnt = a_req;
        OWN_B:   b_gnt = b_req;
        default: begin
          if (a_req && b_req) begin
            a_gnt = last_b_q;
            b_gnt = !last_b_q;
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_addr   = '0;
    mem_dat_in = '0;
    mem_wr_en  = 1'b0;
    if (a_gnt) begin
      mem_addr   = a_addr;
      mem_dat_in = a_wdata;
      mem_wr_en  = a_wr;
    end else if (b_gnt) begin
      mem_addr   = b_addr;
      mem_dat_in = b_wdata;
      mem_wr_en  = b_wr;
    end
  end

  // lock_cnt holds the grants already taken in the burst; the grant that brings the
  // burst to MAX_LOCK releases ownership, so a burst never exceeds MAX_LOCK grants.
  always_comb begin
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    last_b_d   = last_b_q;
    cnt_inc    = lock_cnt_q + 1'b1;
    if (a_gnt) begin
      last_b_d = 1'b0;
    end else if (b_gnt) begin
      last_b_d = 1'b1;
    end
    unique case (owner_q)
      OWN_A: begin
        if (a_req && a_lock && (cnt_inc < CW'(MAX_LOCK))) begin
          lock_cnt_d = cnt_inc;
        end else begin
          owner_d    = OWN_NONE;
          lock_cnt_d = '0;
        end
      end
      OWN_B: begin
        if (b_req && b_lock && (cnt_inc < CW'(MAX_LOCK))) begin
          lock_cnt_d = cnt_inc;
        end else begin
          owner_d    = OWN_NONE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        owner_d = OWN_NONE;
        if (a_gnt && a_lock && (MAX_LOCK > 1)) begin
          owner_d    = OWN_A;
          lock_cnt_d = CW'(1);
        end else if (b_gnt && b_lock && (MAX_LOCK > 1)) begin
          owner_d    = OWN_B;
          lock_cnt_d = CW'(1);
        end
      end
    endcase
  end

  assign a_rvalid_d = a_gnt && !a_wr;
  assign b_rvalid_d = b_gnt && !b_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      last_b_q   <= 1'b1;
      lock_cnt_q <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      last_b_q   <= last_b_d;
      lock_cnt_q <= lock_cnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      if (a_rvalid_d) a_rdata_q <= mem_dat_out;
      if (b_rvalid_d) b_rdata_q <= mem_dat_out;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule
